// File: rtl/mcycle_scheduler.sv
// Multicycle execute scheduler: issues start pulses to the multiplier or FPU,
// stalls the pipeline while the unit is busy and frames the result write-back.
module mcycle_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             MStart,
  input  logic             FPUStart,
  input  logic             Flush,
  input  logic             MulDone,
  input  logic             FPUDone,
  input  logic             ErrClr,
  output logic             MulGo,
  output logic             FPUGo,
  output logic             Abort,
  output logic             Stall,
  output logic             ResultWE,
  output logic             ResultSel,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       ErrStatus
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    FPU_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] cycle_count_nxt;
  logic             mul_go_nxt;
  logic             fpu_go_nxt;
  logic             abort_nxt;
  logic             result_sel_nxt;
  logic [1:0]       err_set;
  logic [1:0]       err_nxt;
  logic             busy;
  logic             unit_done;

  assign busy      = (state == MUL_BUSY) || (state == FPU_BUSY);
  // Only the done pulse of the unit actually running is honoured.
  assign unit_done = ((state == MUL_BUSY) && MulDone) || ((state == FPU_BUSY) && FPUDone);

  assign Stall    = ((state == IDLE) && (MStart || FPUStart) && !Flush) || busy;
  assign ResultWE = (state == DONE) && !Flush;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    cycle_count_nxt = CycleCount;
    mul_go_nxt      = 1'b0;
    fpu_go_nxt      = 1'b0;
    abort_nxt       = 1'b0;
    result_sel_nxt  = ResultSel;
    err_set         = 2'b00;

    unique case (state)
      IDLE: begin
        if (!Flush) begin
          if (MStart) begin
            state_nxt  = MUL_BUSY;
            mul_go_nxt = 1'b1;
            count_nxt  = CNT_ONE;
            err_set[1] = FPUStart;
          end else if (FPUStart) begin
            state_nxt  = FPU_BUSY;
            fpu_go_nxt = 1'b1;
            count_nxt  = CNT_ONE;
          end
        end
      end

      MUL_BUSY, FPU_BUSY: begin
        if (Flush) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (unit_done) begin
          state_nxt       = DONE;
          cycle_count_nxt = count;
          result_sel_nxt  = (state == FPU_BUSY);
        end else if (count == TIMEOUT_CNT) begin
          state_nxt  = IDLE;
          abort_nxt  = 1'b1;
          err_set[0] = 1'b1;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end

      DONE: begin
        // The departing instruction's request is still up; do not re-sample it.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A newly raised error wins over a same-cycle clear.
    err_nxt = (ErrClr ? 2'b00 : ErrStatus) | err_set;
  end

  // Registered outputs and datapath
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count      <= '0;
      CycleCount <= '0;
      ErrStatus  <= 2'b00;
      ResultSel  <= 1'b0;
      MulGo      <= 1'b0;
      FPUGo      <= 1'b0;
      Abort      <= 1'b0;
    end else begin
      count      <= count_nxt;
      CycleCount <= cycle_count_nxt;
      ErrStatus  <= err_nxt;
      ResultSel  <= result_sel_nxt;
      MulGo      <= mul_go_nxt;
      FPUGo      <= fpu_go_nxt;
      Abort      <= abort_nxt;
    end
  end

`ifndef SYNTHESIS
  // Start, cancel and write-back pulses never overlap.
  always @(posedge CLK) begin
    if (!Reset) begin
      assert ($onehot0({MulGo, FPUGo, Abort, ResultWE}))
        else $error("overlapping Go/Abort/ResultWE pulses");
    end
  end
`endif

endmodule

// File: tb/tb_mcycle_scheduler.sv
// Directed-vector bench for mcycle_scheduler with TIMEOUT=8.
module tb_mcycle_scheduler;

  localparam int unsigned CNT_W = 8;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             MStart, FPUStart, Flush, MulDone, FPUDone, ErrClr;
  logic             MulGo, FPUGo, Abort, Stall, ResultWE, ResultSel;
  logic [CNT_W-1:0] CycleCount;
  logic [1:0]       ErrStatus;

  int vectors    = 0;
  int miscompares = 0;

  mcycle_scheduler #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .MStart     (MStart),
    .FPUStart   (FPUStart),
    .Flush      (Flush),
    .MulDone    (MulDone),
    .FPUDone    (FPUDone),
    .ErrClr     (ErrClr),
    .MulGo      (MulGo),
    .FPUGo      (FPUGo),
    .Abort      (Abort),
    .Stall      (Stall),
    .ResultWE   (ResultWE),
    .ResultSel  (ResultSel),
    .CycleCount (CycleCount),
    .ErrStatus  (ErrStatus)
  );

  always #5 CLK = ~CLK;

  // Stimulus bits: {MStart, FPUStart, Flush, MulDone, FPUDone, ErrClr}
  task automatic apply(input logic [5:0] v);
    {MStart, FPUStart, Flush, MulDone, FPUDone, ErrClr} = v;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Observed control bits: {MulGo, FPUGo, Abort, Stall, ResultWE}
  function automatic logic [4:0] ctl();
    return {MulGo, FPUGo, Abort, Stall, ResultWE};
  endfunction

  task automatic test_reset;
    Reset = 1'b1;
    apply(6'b000000);
    tick;
    tick;
    #1;
    vectors++;
    if (ctl() !== 5'b00000) begin
      $display("FAIL reset ctl got %b want %b", ctl(), 5'b00000); miscompares++;
    end
    vectors++;
    if ({CycleCount, ErrStatus, ResultSel} !== 11'd0) begin
      $display("FAIL reset regs got cc=%0d err=%b sel=%b want 0", CycleCount, ErrStatus, ResultSel);
      miscompares++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_multiply;
    logic [5:0] st [8];
    logic [4:0] ex [8];
    st = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100100, 6'b100000, 6'b000000};
    ex = '{5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00001, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL mul[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      if (i == 6) begin
        vectors++;
        if (CycleCount !== 8'd5 || ResultSel !== 1'b0) begin
          $display("FAIL mul result got cc=%0d sel=%b want cc=5 sel=0", CycleCount, ResultSel);
          miscompares++;
        end
      end
      tick;
    end
  endtask

  task automatic test_fpu_zero_latency;
    logic [5:0] st [4];
    logic [4:0] ex [4];
    st = '{6'b010000, 6'b010010, 6'b010000, 6'b000000};
    ex = '{5'b00010, 5'b01010, 5'b00001, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL fpu[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      if (i == 2) begin
        vectors++;
        if (CycleCount !== 8'd1 || ResultSel !== 1'b1) begin
          $display("FAIL fpu result got cc=%0d sel=%b want cc=1 sel=1", CycleCount, ResultSel);
          miscompares++;
        end
      end
      tick;
    end
  endtask

  task automatic test_timeout;
    logic [5:0] st [11];
    logic [4:0] ex [11];
    st = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
           6'b100000, 6'b100000, 6'b100000, 6'b000000, 6'b000000};
    ex = '{5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b00010, 5'b00010,
           5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b00000};
    for (int i = 0; i < 11; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL timeout[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      if (i == 9) begin
        vectors++;
        if (ErrStatus !== 2'b01 || CycleCount !== 8'd1) begin
          $display("FAIL timeout err got err=%b cc=%0d want err=01 cc=1", ErrStatus, CycleCount);
          miscompares++;
        end
      end
      tick;
    end
    apply(6'b000001);
    tick;
    apply(6'b000000);
    #1;
    vectors++;
    if (ErrStatus !== 2'b00) begin
      $display("FAIL errclr got %b want 00", ErrStatus); miscompares++;
    end
  endtask

  task automatic test_conflict_flush;
    logic [5:0] st [8];
    logic [4:0] ex [8];
    // Flush blocks IDLE acceptance; conflict with ErrClr in the same cycle still sets bit 1.
    st = '{6'b111000, 6'b110001, 6'b110000, 6'b110000, 6'b111000, 6'b000100, 6'b000000, 6'b000000};
    ex = '{5'b00000, 5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b00100, 5'b00000, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL conflict[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      if (i == 2) begin
        vectors++;
        if (ErrStatus !== 2'b10) begin
          $display("FAIL conflict err got %b want 10", ErrStatus); miscompares++;
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_midop;
    apply(6'b010000);
    tick;
    apply(6'b010000);
    #1;
    vectors++;
    if (ctl() !== 5'b01010) begin
      $display("FAIL midop go ctl got %b want 01010", ctl()); miscompares++;
    end
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    apply(6'b000010);
    #1;
    vectors++;
    if (ctl() !== 5'b00000) begin
      $display("FAIL midop reset ctl got %b want 00000", ctl()); miscompares++;
    end
    vectors++;
    if ({CycleCount, ErrStatus, ResultSel} !== 11'd0) begin
      $display("FAIL midop regs got cc=%0d err=%b sel=%b want 0", CycleCount, ErrStatus, ResultSel);
      miscompares++;
    end
    tick;
    apply(6'b000000);
    #1;
    vectors++;
    if (ctl() !== 5'b00000 || CycleCount !== 8'd0) begin
      $display("FAIL midop late done got ctl=%b cc=%0d want 00000 cc=0", ctl(), CycleCount);
      miscompares++;
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [5:0] st [11];
    logic [4:0] ex [11];
    // FPUDone while the multiplier runs must be ignored.
    st = '{6'b100000, 6'b100000, 6'b100010, 6'b100100, 6'b100000, 6'b100000,
           6'b100000, 6'b100000, 6'b100100, 6'b000000, 6'b000000};
    ex = '{5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b00001, 5'b00010,
           5'b10010, 5'b00010, 5'b00010, 5'b00001, 5'b00000};
    for (int i = 0; i < 11; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL b2b[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      if (i == 4 || i == 9) begin
        vectors++;
        if (CycleCount !== 8'd3 || ResultSel !== 1'b0) begin
          $display("FAIL b2b[%0d] result got cc=%0d sel=%b want cc=3 sel=0", i, CycleCount, ResultSel);
          miscompares++;
        end
      end
      tick;
    end
  endtask

  task automatic test_flush_done;
    logic [5:0] st [4];
    logic [4:0] ex [4];
    st = '{6'b010000, 6'b010010, 6'b011000, 6'b000000};
    ex = '{5'b00010, 5'b01010, 5'b00000, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      #1;
      vectors++;
      if (ctl() !== ex[i]) begin
        $display("FAIL flushdone[%0d] ctl got %b want %b", i, ctl(), ex[i]); miscompares++;
      end
      tick;
    end
  endtask

  initial begin
    Reset = 1'b1;
    apply(6'b000000);
    test_reset;
    test_multiply;
    test_fpu_zero_latency;
    test_timeout;
    test_conflict_flush;
    test_reset_midop;
    test_back_to_back;
    test_flush_done;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
